// File: rtl/pc_defs.sv
// Shared definitions for the program-counter sequencer: reset address,
// state encoding, redirect-select codes and target alignment helper.
package pc_defs;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BR   = 2'd1,
    SEL_J    = 2'd2,
    SEL_JR   = 2'd3
  } sel_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incr.sv
// 32-bit +4 incrementer producing the sequential fetch / link address.
module pc_incr (
  input  logic [31:0] pc_i,
  output logic [31:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential advance, stall hold, and prioritised
// redirects that take effect after a single delay-slot fetch.
module pc_sequencer
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        j_req,
  input  logic [31:0] j_target,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        slot_pending,
  output logic        addr_err,
  output logic        req_drop
);

  state_e      state_q, state_d;
  sel_e        sel;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] win_target;
  logic        addr_err_q, addr_err_d;
  logic        req_drop_q, req_drop_d;

  pc_incr u_incr (
    .pc_i      (pc_q),
    .pc_plus4_o(pc_plus4)
  );

  always_comb begin
    sel        = SEL_NONE;
    win_target = '0;
    if (jr_req) begin
      sel        = SEL_JR;
      win_target = jr_target;
    end else if (j_req) begin
      sel        = SEL_J;
      win_target = j_target;
    end else if (br_req) begin
      sel        = SEL_BR;
      win_target = br_target;
    end
  end

  // Pulses default low so a stalled edge clears them.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    addr_err_d = 1'b0;
    req_drop_d = 1'b0;
    if (!stall) begin
      unique case (state_q)
        SEQ: begin
          pc_d = pc_plus4;
          if (sel != SEL_NONE) begin
            state_d    = SLOT;
            target_d   = align_word(win_target);
            addr_err_d = |win_target[1:0];
          end
        end
        SLOT: begin
          pc_d       = target_q;
          state_d    = SEQ;
          req_drop_d = jr_req | j_req | br_req;
        end
        default: state_d = SEQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEQ;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      addr_err_q <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      addr_err_q <= addr_err_d;
      req_drop_q <= req_drop_d;
    end
  end

  assign pc           = pc_q;
  assign slot_pending = (state_q == SLOT);
  assign addr_err     = addr_err_q;
  assign req_drop     = req_drop_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table through a scoreboard queue, plus
// async-reset and wrap-around sequences on a second instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_req = 1'b0, j_req = 1'b0, jr_req = 1'b0;
  logic [31:0] br_target = '0, j_target = '0, jr_target = '0;

  logic [31:0] pc, pc_plus4, pc_w, pc_plus4_w;
  logic        slot_pending, addr_err, req_drop;
  logic        slot_pending_w, addr_err_w, req_drop_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_req(br_req), .br_target(br_target),
    .j_req(j_req), .j_target(j_target),
    .jr_req(jr_req), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .slot_pending(slot_pending),
    .addr_err(addr_err), .req_drop(req_drop)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall),
    .br_req(br_req), .br_target(br_target),
    .j_req(j_req), .j_target(j_target),
    .jr_req(jr_req), .jr_target(jr_target),
    .pc(pc_w), .pc_plus4(pc_plus4_w), .slot_pending(slot_pending_w),
    .addr_err(addr_err_w), .req_drop(req_drop_w)
  );

  typedef struct {
    logic        stall, br, j, jr;
    logic [31:0] bt, jt, jrt;
    logic [31:0] pc;
    logic        slot, aerr, drop;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        slot, aerr, drop;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[21];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic jr, input logic [31:0] jrt,
                              input logic [31:0] epc, input logic eslot,
                              input logic eaerr, input logic edrop);
    vec_t v;
    v.stall = s; v.br = b; v.bt = bt; v.j = j; v.jt = jt; v.jr = jr; v.jrt = jrt;
    v.pc = epc; v.slot = eslot; v.aerr = eaerr; v.drop = edrop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " pc"}, pc, e.pc);
    check({tag, " pc_plus4"}, pc_plus4, e.pc + 32'd4);
    check({tag, " slot_pending"}, {31'd0, slot_pending}, {31'd0, e.slot});
    check({tag, " addr_err"}, {31'd0, addr_err}, {31'd0, e.aerr});
    check({tag, " req_drop"}, {31'd0, req_drop}, {31'd0, e.drop});
  endtask

  // Drive one cycle's inputs at the falling edge, compare after the rising edge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    stall = v.stall;
    br_req = v.br; br_target = v.bt;
    j_req = v.j; j_target = v.jt;
    jr_req = v.jr; jr_target = v.jrt;
    e.pc = v.pc; e.slot = v.slot; e.aerr = v.aerr; e.drop = v.drop;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_outputs(tag, sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h300C, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3010, 0, 0, 0);
    tbl[4]  = mk(0, 1, 32'h3100, 0, 0, 0, 0, 32'h3014, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3100, 0, 0, 0);
    tbl[6]  = mk(0, 1, 32'h4000, 1, 32'h5000, 1, 32'h6000, 32'h3104, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h6000, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 32'h3203, 0, 0, 32'h6004, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3200, 0, 0, 0);
    tbl[10] = mk(0, 1, 32'h3300, 0, 0, 0, 0, 32'h3204, 1, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 32'h7000, 32'h3204, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 1, 32'h7000, 32'h3204, 1, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 32'h7000, 32'h3204, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 32'h7000, 32'h3300, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h3304, 0, 0, 0);
    tbl[16] = mk(1, 1, 32'h8000, 0, 0, 0, 0, 32'h3304, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 32'h3308, 0, 0, 0);
    tbl[18] = mk(0, 1, 32'h4002, 0, 0, 0, 0, 32'h330C, 1, 1, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 32'h330C, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 32'h4000, 0, 0, 0);

    // Asynchronous reset between edges, then held across two edges.
    #2 reset = 1'b0;
    #1;
    e.pc = 32'h3000; e.slot = 0; e.aerr = 0; e.drop = 0;
    check_outputs("reset_async", e);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset_held", e);
    check("wrap reset pc", pc_w, 32'hFFFF_FFFC);
    check("wrap reset pc_plus4", pc_plus4_w, 32'h0000_0000);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
      if (i == 0) begin
        check("wrap pc", pc_w, 32'h0000_0000);
        check("wrap pc_plus4", pc_plus4_w, 32'h0000_0004);
        check("wrap addr_err", {31'd0, addr_err_w}, 32'd0);
      end
    end

    // Reset mid-SLOT discards the pending target.
    apply("slot_enter", mk(0, 1, 32'h5000, 0, 0, 0, 0, 32'h4004, 1, 0, 0));
    #2 reset = 1'b0;
    #1;
    e.pc = 32'h3000; e.slot = 0; e.aerr = 0; e.drop = 0;
    check_outputs("reset_mid_slot", e);
    @(posedge clk);
    #1;
    check_outputs("reset_mid_slot_held", e);
    reset = 1'b1;
    apply("post_reset0", mk(0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
    apply("post_reset1", mk(0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));

    check("scoreboard drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
